// File: rtl/cke_gen.sv
// Multi-channel clock-enable generator: one-cycle cke pulses per channel at a
// programmable divide ratio and reset-time phase offset, all on the fabric clock.
module cke_gen #(
    parameter int n = 1,
    parameter int w = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [n*w-1:0] period,
    input  logic [n*w-1:0] phase,
    output logic [n-1:0]   cke,
    output logic           all_started
);

    logic [w-1:0] cnt     [n];
    logic [w-1:0] per_act [n];
    logic [n-1:0] started;

    // Periods of 0 and 1 both mean "every run-cycle".
    function automatic logic [w-1:0] eff(input logic [w-1:0] p);
        return (p < w'(2)) ? w'(1) : p;
    endfunction

    // NOTE: sequential state is assigned with <= so every channel sees the
    // pre-edge values of its neighbours and of itself, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < n; k++) begin
                cnt[k]     <= phase[k*w +: w];
                per_act[k] <= period[k*w +: w];
            end
            cke     <= '0;
            started <= '0;
        end else if (!run) begin
            // Counters freeze so resuming continues the interval exactly.
            cke <= '0;
        end else begin
            for (int k = 0; k < n; k++) begin
                if (cnt[k] == '0) begin
                    cke[k]     <= 1'b1;
                    cnt[k]     <= eff(period[k*w +: w]) - w'(1);
                    per_act[k] <= period[k*w +: w];
                    started[k] <= 1'b1;
                end else begin
                    cke[k] <= 1'b0;
                    cnt[k] <= cnt[k] - w'(1);
                end
            end
        end
    end

    assign all_started = &started;

    // Once a channel has wrapped, its count never exceeds the interval it
    // was reloaded for; a later period change only applies at the next wrap.
    for (genvar k = 0; k < n; k++) begin : g_chk
        a_cnt_in_interval : assert property (
            @(posedge clk) disable iff (rst)
            started[k] |-> (cnt[k] <= eff(per_act[k]) - w'(1))
        );
    end

endmodule

// File: tb/tb_cke_gen.sv
// Directed testbench for cke_gen with n=2, w=8; expected pulse trains are
// hand-derived from the run-edge numbering of each scenario.
module tb_cke_gen;

    localparam int N = 2;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic [N*W-1:0] period;
    logic [N*W-1:0] phase;
    logic [N-1:0]   cke;
    logic           all_started;

    int checks = 0;
    int errors = 0;

    cke_gen #(.n(N), .w(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .period      (period),
        .phase       (phase),
        .cke         (cke),
        .all_started (all_started)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        run    = 1'b1;
        period = {8'd4, 8'd4};
        phase  = {8'd2, 8'd0};
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({all_started, cke} !== 3'b000) begin
                errors++;
                $display("FAIL reset cycle %0d: got {as,cke}=%b expected 000", i, {all_started, cke});
            end
        end
        rst = 1'b0;
    endtask

    // ch0 period 4 phase 0, ch1 period 4 phase 2; phase is changed after
    // reset release and must be ignored.
    task automatic test_divide_phase();
        logic [2:0] exp;
        phase = {8'd7, 8'd7};
        for (int r = 0; r <= 12; r++) begin
            tick();
            exp[0] = (r % 4 == 0);
            exp[1] = (r >= 2) && ((r - 2) % 4 == 0);
            exp[2] = (r >= 2);
            checks++;
            if ({all_started, cke} !== exp) begin
                errors++;
                $display("FAIL divide_phase r=%0d: got {as,cke}=%b expected %b", r, {all_started, cke}, exp);
            end
        end
    endtask

    task automatic test_degenerate();
        rst    = 1'b1;
        run    = 1'b1;
        period = {8'd1, 8'd0};
        phase  = {8'd0, 8'd0};
        tick();
        checks++;
        if ({all_started, cke} !== 3'b000) begin
            errors++;
            $display("FAIL degenerate reset: got %b expected 000", {all_started, cke});
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({all_started, cke} !== 3'b111) begin
                errors++;
                $display("FAIL degenerate run %0d: got %b expected 111", i, {all_started, cke});
            end
        end
        run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({all_started, cke} !== 3'b100) begin
                errors++;
                $display("FAIL degenerate paused %0d: got %b expected 100", i, {all_started, cke});
            end
        end
        run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({all_started, cke} !== 3'b111) begin
                errors++;
                $display("FAIL degenerate resume %0d: got %b expected 111", i, {all_started, cke});
            end
        end
    endtask

    // ch0 period 5 phase 0 (pulses r=0,5); ch1 period 3 phase 1 (r=1,4);
    // run dropped for 7 cycles after r=2.
    task automatic test_pause();
        logic [2:0] exp;
        rst    = 1'b1;
        run    = 1'b1;
        period = {8'd3, 8'd5};
        phase  = {8'd1, 8'd0};
        tick();
        rst = 1'b0;
        for (int r = 0; r <= 2; r++) begin
            tick();
            exp = {r >= 1, r == 1, r == 0};
            checks++;
            if ({all_started, cke} !== exp) begin
                errors++;
                $display("FAIL pause pre r=%0d: got %b expected %b", r, {all_started, cke}, exp);
            end
        end
        run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if ({all_started, cke} !== 3'b100) begin
                errors++;
                $display("FAIL pause hold %0d: got %b expected 100", i, {all_started, cke});
            end
        end
        run = 1'b1;
        for (int r = 3; r <= 5; r++) begin
            tick();
            exp = {1'b1, r == 4, r == 5};
            checks++;
            if ({all_started, cke} !== exp) begin
                errors++;
                $display("FAIL pause post r=%0d: got %b expected %b", r, {all_started, cke}, exp);
            end
        end
    endtask

    // ch0 period 4->3 after r=0 (pulses 0,4,7,10); ch1 period 4 phase 3
    // (pulses 3,7,11). Then a mid-run reset with new phases.
    task automatic test_period_change();
        logic [2:0] exp;
        rst    = 1'b1;
        run    = 1'b1;
        period = {8'd4, 8'd4};
        phase  = {8'd3, 8'd0};
        tick();
        rst = 1'b0;
        for (int r = 0; r <= 11; r++) begin
            tick();
            if (r == 0) period[7:0] = 8'd3;
            exp[0] = (r == 0) || (r == 4) || (r == 7) || (r == 10);
            exp[1] = (r == 3) || (r == 7) || (r == 11);
            exp[2] = (r >= 3);
            checks++;
            if ({all_started, cke} !== exp) begin
                errors++;
                $display("FAIL period_change r=%0d: got %b expected %b", r, {all_started, cke}, exp);
            end
        end
        rst   = 1'b1;
        phase = {8'd0, 8'd1};
        tick();
        checks++;
        if ({all_started, cke} !== 3'b000) begin
            errors++;
            $display("FAIL midrun reset: got %b expected 000", {all_started, cke});
        end
        rst = 1'b0;
        for (int r = 0; r <= 4; r++) begin
            tick();
            exp[0] = (r == 1) || (r == 4);
            exp[1] = (r == 0) || (r == 4);
            exp[2] = (r >= 1);
            checks++;
            if ({all_started, cke} !== exp) begin
                errors++;
                $display("FAIL after_reset r=%0d: got %b expected %b", r, {all_started, cke}, exp);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        run    = 1'b0;
        period = '0;
        phase  = '0;
        test_reset();
        test_divide_phase();
        test_degenerate();
        test_pause();
        test_period_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
